// File: rtl/dmvm_scheduler.sv
// Batch sequencer for the DMVM attention-coefficient engine: one sub-graph in flight at a time.
// Latency: start -> dmvm_valid_o in 2 cycles min; engine ready -> coef_valid_o in 1 cycle.
// Backpressure: coef_ready_i low holds the coefficient set and keeps the engine idle.
module dmvm_scheduler #(
   parameter int NUM_OF_NODES   = 168,
   parameter int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
   parameter int SG_W           = 16,
   parameter int TOTAL_W        = 24,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic [SG_W-1:0]           num_subgraphs_i,
   input  logic                      abort_i,
   input  logic                      a_valid_i,
   output logic                      dmvm_valid_o,
   input  logic                      dmvm_ready_i,
   input  logic [NUM_NODE_WIDTH-1:0] num_of_nodes_i,
   output logic                      coef_valid_o,
   input  logic                      coef_ready_i,
   output logic [SG_W-1:0]           coef_sg_idx_o,
   output logic [NUM_NODE_WIDTH-1:0] coef_num_nodes_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_timeout_o,
   output logic [TOTAL_W-1:0]        total_nodes_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_A,
      S_RUN,
      S_HANDOFF,
      S_DONE
   } state_t;

   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t                    state_q, state_d;
   logic [SG_W-1:0]           n_q, n_d;
   logic [SG_W-1:0]           sg_idx_q, sg_idx_d;
   logic [TO_W-1:0]           wd_q, wd_d;
   logic                      dmvm_valid_q, dmvm_valid_d;
   logic                      coef_valid_q, coef_valid_d;
   logic [SG_W-1:0]           coef_sg_idx_q, coef_sg_idx_d;
   logic [NUM_NODE_WIDTH-1:0] coef_num_nodes_q, coef_num_nodes_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic [TOTAL_W-1:0]        total_q, total_d;

   always_comb begin
      state_d          = state_q;
      n_d              = n_q;
      sg_idx_d         = sg_idx_q;
      wd_d             = wd_q;
      dmvm_valid_d     = dmvm_valid_q;
      coef_valid_d     = coef_valid_q;
      coef_sg_idx_d    = coef_sg_idx_q;
      coef_num_nodes_d = coef_num_nodes_q;
      done_d           = 1'b0;
      err_d            = err_q;
      total_d          = total_q;

      case (state_q)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               err_d = 1'b0;
               if (num_subgraphs_i != '0) begin
                  n_d      = num_subgraphs_i;
                  sg_idx_d = '0;
                  total_d  = '0;
                  state_d  = S_WAIT_A;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_WAIT_A: begin
            if (a_valid_i) begin
               state_d      = S_RUN;
               dmvm_valid_d = 1'b1;
               wd_d         = '0;
            end
         end
         S_RUN: begin
            // Engine completion takes precedence over a watchdog expiring in the same cycle.
            if (dmvm_ready_i) begin
               dmvm_valid_d     = 1'b0;
               coef_valid_d     = 1'b1;
               coef_num_nodes_d = num_of_nodes_i;
               coef_sg_idx_d    = sg_idx_q;
               total_d          = total_q + TOTAL_W'(num_of_nodes_i);
               wd_d             = '0;
               state_d          = S_HANDOFF;
            end else if (wd_q == WD_LAST) begin
               err_d        = 1'b1;
               dmvm_valid_d = 1'b0;
               wd_d         = '0;
               state_d      = S_IDLE;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end
         end
         S_HANDOFF: begin
            if (coef_valid_q && coef_ready_i) begin
               coef_valid_d = 1'b0;
               if (sg_idx_q == n_q - SG_W'(1)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  sg_idx_d     = sg_idx_q + SG_W'(1);
                  dmvm_valid_d = 1'b1;
                  wd_d         = '0;
                  state_d      = S_RUN;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort leaves the error flag and node total as they were.
      if (abort_i && (state_q != S_IDLE)) begin
         state_d      = S_IDLE;
         dmvm_valid_d = 1'b0;
         coef_valid_d = 1'b0;
         done_d       = 1'b0;
         wd_d         = '0;
         err_d        = err_q;
         total_d      = total_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_IDLE;
         n_q              <= '0;
         sg_idx_q         <= '0;
         wd_q             <= '0;
         dmvm_valid_q     <= 1'b0;
         coef_valid_q     <= 1'b0;
         coef_sg_idx_q    <= '0;
         coef_num_nodes_q <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         err_q            <= 1'b0;
         total_q          <= '0;
      end else begin
         state_q          <= state_d;
         n_q              <= n_d;
         sg_idx_q         <= sg_idx_d;
         wd_q             <= wd_d;
         dmvm_valid_q     <= dmvm_valid_d;
         coef_valid_q     <= coef_valid_d;
         coef_sg_idx_q    <= coef_sg_idx_d;
         coef_num_nodes_q <= coef_num_nodes_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         err_q            <= err_d;
         total_q          <= total_d;
      end
   end

   assign dmvm_valid_o     = dmvm_valid_q;
   assign coef_valid_o     = coef_valid_q;
   assign coef_sg_idx_o    = coef_sg_idx_q;
   assign coef_num_nodes_o = coef_num_nodes_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign err_timeout_o    = err_q;
   assign total_nodes_o    = total_q;

endmodule

// File: tb/tb_dmvm_scheduler.sv
// Scoreboard bench for dmvm_scheduler: directed scenarios plus randomized batches,
// with a negedge monitor popping expected coefficient sets on each downstream handshake.
module tb_dmvm_scheduler;

   localparam int NN_W    = 8;
   localparam int SG_W    = 16;
   localparam int TOTAL_W = 24;
   localparam int TO      = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                start_i;
   logic [SG_W-1:0]     num_subgraphs_i;
   logic                abort_i;
   logic                a_valid_i;
   logic                dmvm_valid_o;
   logic                dmvm_ready_i;
   logic [NN_W-1:0]     num_of_nodes_i;
   logic                coef_valid_o;
   logic                coef_ready_i;
   logic [SG_W-1:0]     coef_sg_idx_o;
   logic [NN_W-1:0]     coef_num_nodes_o;
   logic                busy_o;
   logic                done_o;
   logic                err_timeout_o;
   logic [TOTAL_W-1:0]  total_nodes_o;

   always #5 clk = ~clk;

   dmvm_scheduler #(
      .NUM_OF_NODES  (168),
      .SG_W          (SG_W),
      .TOTAL_W       (TOTAL_W),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start_i         (start_i),
      .num_subgraphs_i (num_subgraphs_i),
      .abort_i         (abort_i),
      .a_valid_i       (a_valid_i),
      .dmvm_valid_o    (dmvm_valid_o),
      .dmvm_ready_i    (dmvm_ready_i),
      .num_of_nodes_i  (num_of_nodes_i),
      .coef_valid_o    (coef_valid_o),
      .coef_ready_i    (coef_ready_i),
      .coef_sg_idx_o   (coef_sg_idx_o),
      .coef_num_nodes_o(coef_num_nodes_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .err_timeout_o   (err_timeout_o),
      .total_nodes_o   (total_nodes_o)
   );

   typedef struct {
      int idx;
      int nodes;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt    = 0;
   int   total_cnt   = 0;
   int   done_cnt    = 0;
   int   done_model  = 0;
   int   sg_model    = 0;
   int   total_model = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_batch(input int n);
      start_i         = 1'b1;
      num_subgraphs_i = SG_W'(n);
      tick();
      start_i         = 1'b0;
      num_subgraphs_i = SG_W'($urandom);
      sg_model        = 0;
      total_model     = 0;
   endtask

   task automatic wait_dmvm_valid();
      int n = 0;
      while (!dmvm_valid_o && n < 40) begin
         tick();
         n++;
      end
      check("dmvm_valid_seen", longint'(dmvm_valid_o), 1);
   endtask

   // Engine + downstream model for one sub-graph: engine latency, node count, backpressure length.
   task automatic serve(input int nodes, input int lat, input int bp, input bit last);
      exp_t e;
      wait_dmvm_valid();
      for (int i = 0; i < lat; i++) begin
         check("run_hold", longint'(dmvm_valid_o), 1);
         tick();
      end
      dmvm_ready_i   = 1'b1;
      num_of_nodes_i = NN_W'(nodes);
      coef_ready_i   = (bp == 0);
      e.idx          = sg_model;
      e.nodes        = nodes;
      exp_q.push_back(e);
      total_model    = (total_model + nodes) % (1 << TOTAL_W);
      tick();
      dmvm_ready_i   = 1'b0;
      num_of_nodes_i = NN_W'($urandom);
      check("coef_vld_after_rdy", longint'(coef_valid_o), 1);
      check("dmvm_drop", longint'(dmvm_valid_o), 0);
      check("total_nodes", longint'(total_nodes_o), total_model);
      check("no_err", longint'(err_timeout_o), 0);
      for (int i = 0; i < bp; i++) begin
         tick();
         check("bp_dmvm_low", longint'(dmvm_valid_o), 0);
         check("bp_coef_hold", longint'(coef_valid_o), 1);
      end
      coef_ready_i = 1'b1;
      tick();
      check("coef_drop", longint'(coef_valid_o), 0);
      if (!last) begin
         check("next_sg_start", longint'(dmvm_valid_o), 1);
         sg_model++;
      end else begin
         check("done_pulse", longint'(done_o), 1);
         check("busy_in_done", longint'(busy_o), 1);
         tick();
         check("done_one_cycle", longint'(done_o), 0);
         check("busy_fall", longint'(busy_o), 0);
         done_model++;
         check("done_count", done_cnt, done_model);
      end
   endtask

   // Monitor: scoreboard pops, payload stability and single-flight invariant.
   exp_t            mon_e;
   logic            prev_vld = 1'b0;
   logic [SG_W-1:0] prev_idx;
   logic [NN_W-1:0] prev_nodes;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (done_o) done_cnt++;
            if (coef_valid_o) begin
               check("one_in_flight", longint'(dmvm_valid_o), 0);
               if (prev_vld) begin
                  check("stable_idx", longint'(coef_sg_idx_o), longint'(prev_idx));
                  check("stable_nodes", longint'(coef_num_nodes_o), longint'(prev_nodes));
               end
            end
            if (coef_valid_o && coef_ready_i) begin
               check("coef_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  mon_e = exp_q.pop_front();
                  check("coef_idx", longint'(coef_sg_idx_o), mon_e.idx);
                  check("coef_nodes", longint'(coef_num_nodes_o), mon_e.nodes);
               end
               prev_vld = 1'b0;
            end else begin
               prev_vld   = coef_valid_o;
               prev_idx   = coef_sg_idx_o;
               prev_nodes = coef_num_nodes_o;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got t=%0t, expected < 200000", $time);
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      int x;
      rst             = 1'b1;
      start_i         = 1'b0;
      num_subgraphs_i = '0;
      abort_i         = 1'b0;
      a_valid_i       = 1'b0;
      dmvm_ready_i    = 1'b0;
      num_of_nodes_i  = '0;
      coef_ready_i    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dmvm_valid", longint'(dmvm_valid_o), 0);
      check("rst_coef_valid", longint'(coef_valid_o), 0);
      check("rst_coef_idx", longint'(coef_sg_idx_o), 0);
      check("rst_coef_nodes", longint'(coef_num_nodes_o), 0);
      check("rst_busy", longint'(busy_o), 0);
      check("rst_done", longint'(done_o), 0);
      check("rst_err", longint'(err_timeout_o), 0);
      check("rst_total", longint'(total_nodes_o), 0);
      rst = 1'b0;
      tick();

      // Basic batch of three.
      a_valid_i    = 1'b1;
      coef_ready_i = 1'b1;
      start_batch(3);
      check("wait_a_dmvm_low", longint'(dmvm_valid_o), 0);
      check("busy_after_start", longint'(busy_o), 1);
      tick();
      check("start_to_valid_t2", longint'(dmvm_valid_o), 1);
      serve(5, 2, 0, 1'b0);
      serve(7, 0, 0, 1'b0);
      serve(4, 3, 0, 1'b1);
      check("total_16", longint'(total_nodes_o), 16);

      // a_valid held low, then long backpressure on the first set.
      a_valid_i = 1'b0;
      start_batch(2);
      for (int i = 0; i < 10; i++) begin
         check("no_a_valid", longint'(dmvm_valid_o), 0);
         tick();
      end
      check("busy_wait_a", longint'(busy_o), 1);
      a_valid_i = 1'b1;
      tick();
      check("a_valid_to_dmvm", longint'(dmvm_valid_o), 1);
      serve($urandom_range(1, 168), $urandom_range(0, 10), 20, 1'b0);
      serve($urandom_range(1, 168), $urandom_range(0, 10), $urandom_range(0, 3), 1'b1);

      // Watchdog expiry.
      start_batch(2);
      wait_dmvm_valid();
      for (int i = 0; i < TO - 1; i++) begin
         tick();
         check("wd_run_hold", longint'(dmvm_valid_o), 1);
      end
      check("wd_no_err_yet", longint'(err_timeout_o), 0);
      tick();
      check("wd_dmvm_drop", longint'(dmvm_valid_o), 0);
      check("wd_err_set", longint'(err_timeout_o), 1);
      check("wd_idle", longint'(busy_o), 0);
      tick();
      check("wd_err_sticky", longint'(err_timeout_o), 1);
      check("wd_no_done", done_cnt, done_model);
      start_batch(1);
      check("err_clear_on_start", longint'(err_timeout_o), 0);
      // Ready arrives exactly on the watchdog's last cycle.
      serve($urandom_range(1, 168), TO - 1, 0, 1'b1);

      // Abort during handoff, then a stray engine pulse.
      start_batch(2);
      wait_dmvm_valid();
      coef_ready_i   = 1'b0;
      x              = $urandom_range(1, 168);
      dmvm_ready_i   = 1'b1;
      num_of_nodes_i = NN_W'(x);
      total_model    = x;
      tick();
      dmvm_ready_i = 1'b0;
      check("abort_pre_coef", longint'(coef_valid_o), 1);
      repeat (3) tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("abort_coef_drop", longint'(coef_valid_o), 0);
      check("abort_dmvm_low", longint'(dmvm_valid_o), 0);
      check("abort_idle", longint'(busy_o), 0);
      check("abort_total_kept", longint'(total_nodes_o), total_model);
      dmvm_ready_i   = 1'b1;
      num_of_nodes_i = NN_W'($urandom_range(1, 168));
      tick();
      dmvm_ready_i = 1'b0;
      tick();
      check("stray_coef_low", longint'(coef_valid_o), 0);
      check("stray_idle", longint'(busy_o), 0);
      check("stray_total", longint'(total_nodes_o), total_model);
      check("abort_no_done", done_cnt, done_model);
      coef_ready_i = 1'b1;
      start_batch(1);
      serve($urandom_range(1, 168), $urandom_range(0, 10), 0, 1'b1);

      // Zero-length batch.
      start_i         = 1'b1;
      num_subgraphs_i = '0;
      tick();
      start_i = 1'b0;
      check("n0_done", longint'(done_o), 1);
      check("n0_busy", longint'(busy_o), 0);
      tick();
      check("n0_done_drop", longint'(done_o), 0);
      check("n0_busy_after", longint'(busy_o), 0);
      done_model++;
      check("n0_done_count", done_cnt, done_model);

      // Start together with abort in IDLE is ignored.
      start_i         = 1'b1;
      abort_i         = 1'b1;
      num_subgraphs_i = 16'd3;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      check("start_abort_busy", longint'(busy_o), 0);
      check("start_abort_done", longint'(done_o), 0);

      // Start while busy must not reload N.
      a_valid_i = 1'b0;
      start_batch(2);
      tick();
      start_i         = 1'b1;
      num_subgraphs_i = 16'd5;
      tick();
      start_i   = 1'b0;
      check("busy_start_ignored", longint'(busy_o), 1);
      a_valid_i = 1'b1;
      serve($urandom_range(1, 168), $urandom_range(0, 10), 0, 1'b0);
      serve($urandom_range(1, 168), $urandom_range(0, 10), 0, 1'b1);

      // Randomized batches.
      for (int b = 0; b < 4; b++) begin
         n = $urandom_range(1, 4);
         start_batch(n);
         for (int s = 0; s < n; s++)
            serve($urandom_range(0, 168), $urandom_range(0, 12), $urandom_range(0, 4), s == n - 1);
      end

      tick();
      check("scoreboard_empty", exp_q.size(), 0);
      check("final_done_count", done_cnt, done_model);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
